// File: rtl/mips_if_pkg.sv
// rtl/mips_if_pkg.sv - shared widths, opcodes and fetch FSM encoding for mips_if
package mips_if_pkg;

    localparam int INST_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int RFIDX_W = 5;

    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06;
    localparam logic [5:0] OP_BGTZ = 6'h07;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } if_state_t;

    function automatic logic is_cond_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ);
    endfunction

endpackage

// File: rtl/mips_if_bpu.sv
// rtl/mips_if_bpu.sv - static predictor: backward conditional branches and j/jal taken
module mips_if_bpu
    import mips_if_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    input  logic [ADDR_W-1:0] pc_incr,
    output logic              taken,
    output logic [ADDR_W-1:0] target
);

    logic [5:0]        w_op;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_j_target;

    assign w_op        = inst[31:26];
    assign w_br_target = pc_incr + {{14{inst[15]}}, inst[15:0], 2'b00};
    assign w_j_target  = {pc_incr[31:28], inst[25:0], 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = pc_incr;
        if (is_cond_branch(w_op) && inst[15]) begin
            taken  = 1'b1;
            target = w_br_target;
        end else if ((w_op == OP_J) || (w_op == OP_JAL)) begin
            taken  = 1'b1;
            target = w_j_target;
        end
    end

endmodule

// File: rtl/mips_if.sv
// rtl/mips_if.sv - MIPS instruction fetch stage with static prediction, skid buffer and redirect drain
module mips_if
    import mips_if_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
)(
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [DATA_W-1:0]  imem_rdata,
    input  logic               ex_redirect,
    input  logic [ADDR_W-1:0]  ex_redirect_pc,
    input  logic               id_stall,
    output logic               if2id_valid,
    output logic [INST_W-1:0]  if2id_inst,
    output logic [ADDR_W-1:0]  if2id_pc_incr,
    output logic               if2id_prdt_taken,
    output logic [RFIDX_W-1:0] if2id_rs_idx,
    output logic [RFIDX_W-1:0] if2id_rt_idx
);

    if_state_t         r_state;
    if_state_t         w_state_nxt;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] req_addr_q;

    logic              r_valid;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc_incr;
    logic              r_prdt;

    logic              r_skid_valid;
    logic [INST_W-1:0] r_skid_inst;
    logic [ADDR_W-1:0] r_skid_pc_incr;
    logic              r_skid_prdt;

    logic [ADDR_W-1:0] w_pc_incr;
    logic              w_taken;
    logic [ADDR_W-1:0] w_target;
    logic              w_accept;

    assign w_pc_incr = req_addr_q + 32'd4;
    assign w_accept  = !r_valid || !id_stall;

    mips_if_bpu u_bpu (
        .inst    (imem_rdata),
        .pc_incr (w_pc_incr),
        .taken   (w_taken),
        .target  (w_target)
    );

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!ex_redirect)
                    w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (ex_redirect)
                    w_state_nxt = imem_ack ? ST_FETCH : ST_DRAIN;
                else if (imem_ack && !w_accept)
                    w_state_nxt = ST_STALL;
            end
            ST_STALL: begin
                if (ex_redirect || !id_stall)
                    w_state_nxt = ST_FETCH;
            end
            ST_DRAIN: begin
                imem_req = 1'b1;
                if (imem_ack)
                    w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            req_addr_q     <= RESET_PC;
            r_valid        <= 1'b0;
            r_inst         <= '0;
            r_pc_incr      <= '0;
            r_prdt         <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_inst    <= '0;
            r_skid_pc_incr <= '0;
            r_skid_prdt    <= 1'b0;
        end else if (ex_redirect) begin
            pc_q         <= ex_redirect_pc;
            r_valid      <= 1'b0;
            r_skid_valid <= 1'b0;
            // Only retarget the bus when nothing is left outstanding at the old address.
            if (r_state == ST_STALL || (imem_ack && (r_state == ST_FETCH || r_state == ST_DRAIN)))
                req_addr_q <= ex_redirect_pc;
        end else begin
            if (r_valid && !id_stall)
                r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: req_addr_q <= pc_q;
                ST_FETCH: begin
                    if (imem_ack) begin
                        pc_q       <= w_target;
                        req_addr_q <= w_target;
                        if (w_accept) begin
                            r_valid   <= 1'b1;
                            r_inst    <= imem_rdata;
                            r_pc_incr <= w_pc_incr;
                            r_prdt    <= w_taken;
                        end else begin
                            r_skid_valid   <= 1'b1;
                            r_skid_inst    <= imem_rdata;
                            r_skid_pc_incr <= w_pc_incr;
                            r_skid_prdt    <= w_taken;
                        end
                    end
                end
                ST_STALL: begin
                    if (!id_stall && r_skid_valid) begin
                        r_valid      <= 1'b1;
                        r_inst       <= r_skid_inst;
                        r_pc_incr    <= r_skid_pc_incr;
                        r_prdt       <= r_skid_prdt;
                        r_skid_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (imem_ack)
                        req_addr_q <= pc_q;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr        = req_addr_q;
    assign if2id_valid      = r_valid;
    assign if2id_inst       = r_inst;
    assign if2id_pc_incr    = r_pc_incr;
    assign if2id_prdt_taken = r_prdt;
    assign if2id_rs_idx     = r_inst[25:21];
    assign if2id_rt_idx     = r_inst[20:16];

endmodule

// File: tb/tb_mips_if.sv
// tb/tb_mips_if.sv - self-checking bench for mips_if with memory responder and fetch-stream model
module tb_mips_if;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        ex_redirect = 1'b0;
    logic [31:0] ex_redirect_pc = '0;
    logic        id_stall = 1'b0;
    logic        if2id_valid;
    logic [31:0] if2id_inst;
    logic [31:0] if2id_pc_incr;
    logic        if2id_prdt_taken;
    logic [4:0]  if2id_rs_idx;
    logic [4:0]  if2id_rt_idx;

    always #5 clk = ~clk;

    mips_if #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .ex_redirect      (ex_redirect),
        .ex_redirect_pc   (ex_redirect_pc),
        .id_stall         (id_stall),
        .if2id_valid      (if2id_valid),
        .if2id_inst       (if2id_inst),
        .if2id_pc_incr    (if2id_pc_incr),
        .if2id_prdt_taken (if2id_prdt_taken),
        .if2id_rs_idx     (if2id_rs_idx),
        .if2id_rt_idx     (if2id_rt_idx)
    );

    localparam logic [31:0] ADDI = 32'h2149_0001;  // addi $9,$10,1

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem_over [logic [31:0]];
    int          fix_lat = 0;
    bit          rand_lat = 0;
    bit          spur_en = 0;
    bit          pending = 0;
    logic [31:0] paddr = '0;
    int          wait_cnt = 0;

    function automatic logic [31:0] inst_at(input logic [31:0] a);
        if (mem_over.exists(a))
            return mem_over[a];
        return ADDI;
    endfunction

    function automatic void model_next(input logic [31:0] pc, input logic [31:0] ins,
                                       output bit tk, output logic [31:0] npc);
        int unsigned op;
        op  = ins >> 26;
        tk  = 1'b0;
        npc = pc + 32'd4;
        if (op >= 4 && op <= 7 && ins[15]) begin
            tk  = 1'b1;
            npc = pc + 32'd4 + 32'(int'($signed(ins[15:0])) * 4);
        end else if (op == 2 || op == 3) begin
            tk  = 1'b1;
            npc = ((pc + 32'd4) & 32'hF000_0000) + ((ins & 32'h03FF_FFFF) * 32'd4);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Instruction memory: serves one request at a time with programmable latency.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pending  = 0;
                imem_ack = 1'b0;
            end else if (imem_req) begin
                if (!pending) begin
                    pending  = 1;
                    paddr    = imem_addr;
                    wait_cnt = rand_lat ? int'($urandom_range(0, 2)) : fix_lat;
                end else begin
                    n_vec++;
                    if (imem_addr !== paddr) begin
                        n_err++;
                        $display("FAIL addr_stable: imem_addr=%h required %h", imem_addr, paddr);
                    end
                end
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = inst_at(imem_addr);
                    pending    = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wait_cnt--;
                end
            end else begin
                pending    = 0;
                imem_ack   = spur_en && ($urandom_range(0, 3) == 0);
                imem_rdata = $urandom;
            end
        end
    end

    task automatic do_reset();
        id_stall = 0; ex_redirect = 0; ex_redirect_pc = '0;
        fix_lat = 0; rand_lat = 0; spur_en = 0;
        rst = 1; step(); step(); rst = 0;
    endtask

    task automatic wait_out(input logic [31:0] pci, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (if2id_valid && if2id_pc_incr == pci) begin
                ok = 1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (4) step();
        rst = 1; step(); step();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        n_vec++; if (if2id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", if2id_valid); end
        n_vec++; if ({if2id_inst, if2id_pc_incr} !== 64'h0) begin n_err++; $display("FAIL rst_data: got %h %h want 0", if2id_inst, if2id_pc_incr); end
        n_vec++; if ({if2id_prdt_taken, if2id_rs_idx, if2id_rt_idx} !== 11'h0) begin n_err++; $display("FAIL rst_misc: got %b %h %h want 0", if2id_prdt_taken, if2id_rs_idx, if2id_rt_idx); end
        rst = 0;
    endtask

    task automatic test_sequential();
        mem_over.delete();
        do_reset();
        step();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL seq_first: req=%b addr=%h want 1 0", imem_req, imem_addr); end
        for (int k = 1; k <= 5; k++) begin
            step();
            n_vec++; if (imem_addr !== 32'(4 * k)) begin n_err++; $display("FAIL seq_addr: got %h want %h", imem_addr, 32'(4 * k)); end
            n_vec++; if (if2id_valid !== 1'b1 || if2id_pc_incr !== 32'(4 * k) || if2id_prdt_taken !== 1'b0 || if2id_inst !== ADDI) begin
                n_err++; $display("FAIL seq_out: v=%b pci=%h pt=%b inst=%h want 1 %h 0 %h", if2id_valid, if2id_pc_incr, if2id_prdt_taken, if2id_inst, 32'(4 * k), ADDI);
            end
        end
        n_vec++; if (if2id_rs_idx !== 5'd10 || if2id_rt_idx !== 5'd9) begin n_err++; $display("FAIL seq_idx: got %0d %0d want 10 9", if2id_rs_idx, if2id_rt_idx); end
    endtask

    task automatic test_branch(input logic [31:0] ins, input logic [31:0] pci,
                               input logic [31:0] exp_addr, input bit exp_tk);
        bit ok;
        mem_over.delete();
        mem_over[pci - 32'd4] = ins;
        do_reset();
        wait_out(pci, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL br_timeout: pc_incr %h never seen", pci); end
        n_vec++; if (imem_addr !== exp_addr) begin n_err++; $display("FAIL br_addr: got %h want %h", imem_addr, exp_addr); end
        n_vec++; if (if2id_prdt_taken !== exp_tk || if2id_inst !== ins) begin n_err++; $display("FAIL br_out: pt=%b inst=%h want %b %h", if2id_prdt_taken, if2id_inst, exp_tk, ins); end
    endtask

    task automatic test_stall();
        mem_over.delete();
        do_reset();
        step(); step();
        id_stall = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) id_stall = 0;
            n_vec++; if (imem_req !== 1'b0 || if2id_valid !== 1'b1 || if2id_pc_incr !== 32'h4) begin
                n_err++; $display("FAIL stall_hold: req=%b v=%b pci=%h want 0 1 4", imem_req, if2id_valid, if2id_pc_incr);
            end
        end
        step();
        n_vec++; if (if2id_valid !== 1'b1 || if2id_pc_incr !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            n_err++; $display("FAIL stall_release: v=%b pci=%h req=%b addr=%h want 1 8 1 8", if2id_valid, if2id_pc_incr, imem_req, imem_addr);
        end
        step();
        n_vec++; if (if2id_pc_incr !== 32'hC) begin n_err++; $display("FAIL stall_resume: got %h want c", if2id_pc_incr); end
    endtask

    task automatic test_redirect(input bit with_rst);
        mem_over.delete();
        do_reset();
        step(); step();
        fix_lat = 2;
        step();
        ex_redirect = 1; ex_redirect_pc = 32'h100;
        step();
        ex_redirect = 0; fix_lat = 0;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if2id_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_hold: req=%b addr=%h v=%b want 1 8 0", imem_req, imem_addr, if2id_valid);
        end
        if (with_rst) begin
            rst = 1;
            step();
            rst = 0;
            n_vec++; if (imem_req !== 1'b0 || if2id_valid !== 1'b0) begin n_err++; $display("FAIL drain_rst: req=%b v=%b want 0 0", imem_req, if2id_valid); end
            step();
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL drain_rst_fetch: req=%b addr=%h want 1 0", imem_req, imem_addr); end
        end else begin
            step();
            n_vec++; if (imem_addr !== 32'h8 || imem_ack !== 1'b1) begin n_err++; $display("FAIL drain_ack: addr=%h ack=%b want 8 1", imem_addr, imem_ack); end
            step();
            n_vec++; if (imem_addr !== 32'h100 || if2id_valid !== 1'b0) begin n_err++; $display("FAIL redir_addr: addr=%h v=%b want 100 0", imem_addr, if2id_valid); end
            step();
            n_vec++; if (if2id_valid !== 1'b1 || if2id_pc_incr !== 32'h104) begin n_err++; $display("FAIL redir_out: v=%b pci=%h want 1 104", if2id_valid, if2id_pc_incr); end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] npc;
        logic [31:0] exp_inst;
        bit          tk;
        int          consumed;
        mem_over.delete();
        for (int a = 0; a < 128; a++) begin
            int          k;
            logic [15:0] imm;
            logic [31:0] w;
            k   = $urandom_range(0, 9);
            imm = 16'($urandom_range(0, 16)) - 16'd8;
            if (k <= 4)      w = {6'h08, 26'($urandom)};
            else if (k <= 6) w = {6'(4 + $urandom_range(0, 3)), 10'($urandom), imm};
            else if (k == 7) w = {6'(2 + $urandom_range(0, 1)), 26'($urandom_range(0, 127))};
            else             w = {6'h00, 26'($urandom)};
            mem_over[32'(a * 4)] = w;
        end
        do_reset();
        rand_lat = 1; spur_en = 1;
        exp_pc = 32'h0; consumed = 0;
        repeat (2000) begin
            id_stall       = ($urandom_range(0, 9) < 3);
            ex_redirect    = ($urandom_range(0, 49) == 0);
            ex_redirect_pc = 32'($urandom_range(0, 127)) << 2;
            #1;
            if (if2id_valid && !id_stall) begin
                exp_inst = inst_at(exp_pc);
                model_next(exp_pc, exp_inst, tk, npc);
                n_vec++;
                if (if2id_pc_incr !== exp_pc + 32'd4 || if2id_inst !== exp_inst || if2id_prdt_taken !== tk) begin
                    n_err++;
                    $display("FAIL rand_stream: pci=%h inst=%h pt=%b want %h %h %b", if2id_pc_incr, if2id_inst, if2id_prdt_taken, exp_pc + 32'd4, exp_inst, tk);
                end
                exp_pc = npc;
                consumed++;
            end
            if (ex_redirect)
                exp_pc = ex_redirect_pc;
            step();
        end
        id_stall = 0; ex_redirect = 0; spur_en = 0;
        n_vec++; if (consumed < 100) begin n_err++; $display("FAIL rand_progress: consumed %0d want >= 100", consumed); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch(32'h1000_FFFC, 32'h14, 32'h04, 1'b1);
        test_branch(32'h1000_0004, 32'h14, 32'h14, 1'b0);
        test_branch(32'h0C00_0100, 32'h24, 32'h400, 1'b1);
        test_stall();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_if.md
MIPS_IF -- requirements
Module: mips_if

Interface
REQ-001 SHALL use one clock `clk`; reset `rst` is synchronous and active-high.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, PC fetched first after reset.
REQ-003 Ports (name direction width meaning):
- clk  in  1  clock
- rst  in  1  sync active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch word address
- imem_ack  in  1  response valid
- imem_rdata  in  32  instruction, valid with imem_ack
- ex_redirect  in  1  flush/redirect from EX (mispredict)
- ex_redirect_pc  in  32  redirect target
- id_stall  in  1  ID cannot accept a new instruction
- if2id_valid  out  1  ID-facing instruction valid
- if2id_inst  out  32  instruction
- if2id_pc_incr  out  32  fetch PC + 4
- if2id_prdt_taken  out  1  static prediction taken
- if2id_rs_idx  out  5  inst[25:21]
- if2id_rt_idx  out  5  inst[20:16]

Function
REQ-004 SHALL hold PC register pc_q and request-address register req_addr_q; imem_addr SHALL equal req_addr_q.
REQ-005 FSM states SHALL be IDLE, FETCH, STALL, DRAIN.
REQ-006 IDLE: imem_req=0; next cycle go to FETCH with req_addr_q<=pc_q.
REQ-007 FETCH: imem_req=1; imem_addr SHALL stay stable until imem_ack, with one outstanding request max.
REQ-008 On imem_ack in FETCH, the block SHALL compute next_pc by static prediction; pc_q<=next_pc and req_addr_q<=next_pc, issuing back-to-back requests.
REQ-009 Prediction:
- beq/bne/blez/bgtz (opcode 04-07) with imm[15]=1: taken, target = pc+4 + (sext(imm)<<2).
- j/jal (02/03): taken, target = {pc_incr[31:28], inst[25:0], 2'b00}.
- Otherwise: not taken, pc+4.
- All address arithmetic is mod 2^32.
REQ-010 When ID can accept (!if2id_valid || !id_stall), ack data SHALL load the if2id_* registers next edge with if2id_valid=1, giving 1-cycle latency ack→output.
REQ-011 If ID cannot accept at ack, data+pc_incr+prdt SHALL go to a 1-entry skid buffer, with FSM→STALL and imem_req=0.
REQ-012 STALL: when id_stall=0, skid SHALL move to outputs next edge and FSM→FETCH.
REQ-013 When if2id_valid && !id_stall and no new load occurs, if2id_valid SHALL clear next edge.
REQ-014 ex_redirect SHALL have highest priority in every state:
- pc_q<=ex_redirect_pc
- if2id_valid<=0
- skid buffer invalidated
REQ-015 Redirect in FETCH:
- With imem_ack the same cycle: data dropped; req_addr_q<=ex_redirect_pc; stay FETCH.
- Without imem_ack: →DRAIN.
REQ-016 DRAIN: imem_req=1 with old req_addr_q until imem_ack; data dropped; then req_addr_q<=pc_q and FSM→FETCH.
REQ-017 Redirect in DRAIN SHALL update pc_q only; redirect in STALL →FETCH at new PC; redirect in IDLE updates pc_q only.
REQ-018 A response arriving with imem_ack when imem_req was 0 SHALL be ignored.

Reset
REQ-019 On rst:
- state=IDLE
- pc_q=req_addr_q=RESET_PC
- skid invalid
- all if2id_* outputs and imem_req = 0
REQ-020 rst mid-request SHALL abandon the in-flight request; imem is required to tolerate imem_req dropping.

Structure
REQ-021 Shared package/defines SHALL hold the width constants (INST/ADDR/DATA=32, RFIDX=5), opcode constants, and FSM state encoding.
REQ-022 Static predictor SHALL be a combinational sub-module mips_if_bpu (inputs: inst, pc_incr; outputs: taken, target).

Verification
REQ-023 Reset, RESET_PC=0, imem_ack every cycle with addi → imem_addr 0,4,8,…; if2id_pc_incr 4,8,12; prdt_taken=0.
REQ-024 beq at 0x10, imm 0xFFFC → next imem_addr 0x04, prdt_taken=1; beq imm 0x0004 → next imem_addr 0x14, prdt_taken=0.
REQ-025 jal at 0x20, inst[25:0]=0x100 → next imem_addr 0x400, prdt_taken=1.
REQ-026 id_stall=1 for 3 cycles over an ack → imem_req=0, outputs frozen, skid held; release → skid instruction on outputs next cycle, then imem_req=1.
REQ-027 ex_redirect to 0x100 while request 0x8 pending, ack 2 cycles later → imem_addr stays 0x8 until ack, data dropped, if2id_valid=0, next imem_addr 0x100.
REQ-028 rst asserted in DRAIN → next cycle IDLE, imem_req=0, then first request at RESET_PC.
